pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Fetch-stage controller that sequences the program counter register.
- Each cycle it decides whether the PC is written and with what value: reset vector, sequential increment, branch/jump target or trap vector.
- Runs the single-outstanding instruction-memory handshake.
- Holds the PC on pipeline stalls and remembers redirects that arrive while a fetch is still in flight.

Parameters:
- PC_SIZE, 18: PC / address width.
- PC_INC, 4: sequential increment.
- RESET_VEC, 0: first fetch address after reset.
- TRAP_VEC, 18'h00100: target on trap or fetch timeout.
- WAIT_MAX, 15: maximum wait cycles per fetch before timeout.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_cur  in  PC_SIZE  current PC register value (fed back).
- pc_write  out  1  PC write enable to PC register.
- pc_next  out  PC_SIZE  value to load into PC.
- imem_req  out  1  instruction fetch request; address = pc_cur.
- imem_ready  in  1  fetch complete, instruction valid this cycle.
- stall  in  1  hazard unit requests IF hold.
- br_taken  in  1  branch resolved taken.
- br_target  in  PC_SIZE  branch target.
- jump  in  1  jump request.
- jump_target  in  PC_SIZE  jump target.
- trap  in  1  exception request.
- fetch_valid  out  1  instruction accepted into IF/ID this cycle.
- flush  out  1  one-cycle pulse: discard younger pipeline contents.
- err  out  1  one-cycle pulse: fetch timeout.
- state_o  out  2  current state (debug).

Behaviour:
- **Reset** (rst=0, any time, including mid-fetch):
  - state=INIT; pending-redirect flag and target cleared; wait counter=0.
  - All outputs 0; pc_next=0.
  - An in-flight memory request is abandoned.
- **Output timing**:
  - pc_write, pc_next, imem_req, fetch_valid, flush and err are combinational from state and current-cycle inputs.
  - The PC register captures pc_next within the same clk period; pc_cur reflects the write by the next rising edge.
- **Redirect** = trap | br_taken | jump. Priority trap > br_taken > jump.
  - Target is TRAP_VEC, br_target or jump_target respectively.
- **States** (encoding INIT=0, FETCH=1, WAIT=2, HOLD=3):
  - INIT: first cycle after reset release.
    - Outputs: pc_write=1, pc_next=RESET_VEC, imem_req=0.
    - Next state: FETCH. Redirect inputs are ignored in INIT.
  - FETCH: imem_req=1. Cases evaluated in priority order:
    1. Redirect present: pc_write=1, pc_next=redirect target, flush=1, fetch_valid=0. If imem_ready=1 the result is dropped and state stays FETCH. If imem_ready=0: pending flag set with target, state -> WAIT, and pc_write is still 1 (the request is re-presented at the new address only after the old one completes; see WAIT).
    2. Else if imem_ready=1 and stall=1: fetch_valid=0, pc_write=0, -> HOLD.
    3. Else if imem_ready=1: fetch_valid=1, pc_write=1, pc_next=(pc_cur+PC_INC) truncated to PC_SIZE (wraps at 2^PC_SIZE), stay FETCH.
    4. Else (imem_ready=0): pc_write=0, counter=1, -> WAIT.
  - WAIT: imem_req=1; counter increments each cycle.
    - Redirect in WAIT: pending target overwritten by the newer (higher-priority-in-cycle) redirect; flush=1 that cycle; pc_write=0.
    - imem_ready=1 with pending set:
      - fetch_valid=0, pc_write=1, pc_next=pending target.
      - Pending cleared, counter=0, -> FETCH.
    - imem_ready=1 without pending: behaves exactly as FETCH cases 2 and 3; counter=0.
    - Timeout: counter reaches WAIT_MAX with imem_ready=0.
      - Outputs: err=1, flush=1, pc_write=1, pc_next=TRAP_VEC.
      - Pending cleared, counter=0, -> FETCH.
  - HOLD: imem_req=0, pc_write=0, fetch_valid=0.
    - Redirect: handled as FETCH case 1 with imem_ready treated as 1, -> FETCH.
    - stall=0: -> FETCH, which refetches the same pc_cur.
- **Invariant**: fetch_valid and flush are never both 1.

Test Plan:
1. Release rst, imem_ready tied 1, no stall → INIT writes 0; fetch_valid on cycles 2..5 with pc_cur 0,4,8,12.
2. pc_cur=3FFFC, sequential fetch → pc_next=0 (wrap).
3. stall=1 for 3 cycles after fetch at 0x10 → HOLD, pc_write=0, imem_req=0; then FETCH refetches 0x10.
4. Same cycle trap=1, br_taken=1 (br_target 0x40), jump=1 → pc_next=0x100, flush=1, fetch_valid=0.
5. imem_ready low 4 cycles; br_taken (target 0x80) in wait cycle 2 → flush pulse then; on ready: fetch_valid=0, pc_next=0x80; next fetch at 0x80.
6. imem_ready held low → err=1 and pc_next=0x100 on the 15th wait cycle. Separately, rst asserted mid-WAIT → all outputs 0 immediately; INIT follows release.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_sequencer
//  Purpose  : Fetch-stage controller. Decides each cycle whether the PC
//             register is written and with what value (reset vector,
//             sequential increment, branch/jump target or trap vector). It
//             also runs a single-outstanding instruction-memory handshake,
//             holds the PC on stalls, and remembers a redirect that arrives
//             while a fetch is still in flight.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, rising edge
//    rst          in   asynchronous reset, active low
//    pc_cur       in   current PC register value (fed back)
//    pc_write     out  PC register write enable
//    pc_next      out  value to load into the PC register
//    imem_req     out  instruction fetch request (address = pc_cur)
//    imem_ready   in   fetch complete, instruction valid this cycle
//    stall        in   hazard unit requests an IF hold
//    br_taken     in   branch resolved taken
//    br_target    in   branch target
//    jump         in   jump request
//    jump_target  in   jump target
//    trap         in   exception request
//    fetch_valid  out  instruction accepted into IF/ID this cycle
//    flush        out  one-cycle pulse: discard younger pipeline contents
//    err          out  one-cycle pulse: fetch timeout
//    state_o      out  current state (debug)
// ============================================================================
module pc_fetch_sequencer #(
  parameter int                 PC_SIZE   = 18,
  parameter int                 PC_INC    = 4,
  parameter logic [PC_SIZE-1:0] RESET_VEC = '0,
  parameter logic [PC_SIZE-1:0] TRAP_VEC  = 18'h00100,
  parameter int                 WAIT_MAX  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] pc_cur,
  output logic               pc_write,
  output logic [PC_SIZE-1:0] pc_next,
  output logic               imem_req,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_SIZE-1:0] br_target,
  input  logic               jump,
  input  logic [PC_SIZE-1:0] jump_target,
  input  logic               trap,
  output logic               fetch_valid,
  output logic               flush,
  output logic               err,
  output logic [1:0]         state_o
);

  // Counter must be able to hold WAIT_MAX itself.
  localparam int                 c_CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(WAIT_MAX);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [PC_SIZE-1:0] c_PC_INC   = PC_SIZE'(PC_INC);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_pend;
  logic                 w_pend_nxt;
  logic [PC_SIZE-1:0]   r_pend_tgt;
  logic [PC_SIZE-1:0]   w_pend_tgt_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  logic                 w_redir;
  logic [PC_SIZE-1:0]   w_redir_tgt;
  logic [PC_SIZE-1:0]   w_pc_inc;

  logic                 w_pc_write;
  logic [PC_SIZE-1:0]   w_pc_next;
  logic                 w_imem_req;
  logic                 w_fetch_valid;
  logic                 w_flush;
  logic                 w_err;

  // --------------------------------------------------------------------------
  // Redirect decode: trap beats branch beats jump.
  // --------------------------------------------------------------------------
  assign w_redir     = trap | br_taken | jump;
  assign w_redir_tgt = trap     ? TRAP_VEC  :
                       br_taken ? br_target :
                                  jump_target;

  // Sequential increment wraps naturally at 2^PC_SIZE.
  assign w_pc_inc = pc_cur + c_PC_INC;

  // --------------------------------------------------------------------------
  // State, pending redirect and wait counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_INIT;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_tgt <= w_pend_tgt_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    w_pend_tgt_nxt = r_pend_tgt;
    w_cnt_nxt      = r_cnt;
    w_pc_write     = 1'b0;
    w_pc_next      = '0;
    w_imem_req     = 1'b0;
    w_fetch_valid  = 1'b0;
    w_flush        = 1'b0;
    w_err          = 1'b0;

    case (r_state)
      ST_INIT: begin
        // Redirects are deliberately ignored on the very first cycle.
        w_pc_write     = 1'b1;
        w_pc_next      = RESET_VEC;
        w_pend_nxt     = 1'b0;
        w_cnt_nxt      = '0;
        w_state_nxt    = ST_FETCH;
      end

      ST_FETCH: begin
        w_imem_req = 1'b1;
        if (w_redir) begin
          w_pc_write = 1'b1;
          w_pc_next  = w_redir_tgt;
          w_flush    = 1'b1;
          if (!imem_ready) begin
            // Old request still outstanding: let it drain in WAIT, then
            // reload the target so the new address is fetched afterwards.
            w_pend_nxt     = 1'b1;
            w_pend_tgt_nxt = w_redir_tgt;
            w_cnt_nxt      = c_CNT_ONE;
            w_state_nxt    = ST_WAIT;
          end
        end else if (imem_ready && stall) begin
          w_state_nxt = ST_HOLD;
        end else if (imem_ready) begin
          w_fetch_valid = 1'b1;
          w_pc_write    = 1'b1;
          w_pc_next     = w_pc_inc;
        end else begin
          w_cnt_nxt   = c_CNT_ONE;
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        w_imem_req = 1'b1;
        if (!imem_ready && (r_cnt >= c_WAIT_MAX)) begin
          // Timeout wins over any redirect arriving in the same cycle.
          w_err       = 1'b1;
          w_flush     = 1'b1;
          w_pc_write  = 1'b1;
          w_pc_next   = TRAP_VEC;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FETCH;
        end else if (imem_ready && w_redir) begin
          // Completion coincides with a fresh redirect: the fresh one is
          // the youngest decision, so it supersedes any pending target.
          w_flush     = 1'b1;
          w_pc_write  = 1'b1;
          w_pc_next   = w_redir_tgt;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FETCH;
        end else if (w_redir) begin
          w_flush        = 1'b1;
          w_pend_nxt     = 1'b1;
          w_pend_tgt_nxt = w_redir_tgt;
          w_cnt_nxt      = r_cnt + c_CNT_ONE;
        end else if (imem_ready && r_pend) begin
          w_pc_write  = 1'b1;
          w_pc_next   = r_pend_tgt;
          w_pend_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_FETCH;
        end else if (imem_ready) begin
          w_cnt_nxt = '0;
          if (stall) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_fetch_valid = 1'b1;
            w_pc_write    = 1'b1;
            w_pc_next     = w_pc_inc;
            w_state_nxt   = ST_FETCH;
          end
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      ST_HOLD: begin
        // No request is outstanding here, so a redirect can be applied
        // directly, as if the memory had already completed.
        if (w_redir) begin
          w_flush     = 1'b1;
          w_pc_write  = 1'b1;
          w_pc_next   = w_redir_tgt;
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_FETCH;
        end else if (!stall) begin
          // PC was not advanced, so FETCH re-requests the same address.
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: forced to zero while reset is held, including the INIT write.
  // --------------------------------------------------------------------------
  assign pc_write    = rst & w_pc_write;
  assign pc_next     = rst ? w_pc_next : '0;
  assign imem_req    = rst & w_imem_req;
  assign fetch_valid = rst & w_fetch_valid;
  assign flush       = rst & w_flush;
  assign err         = rst & w_err;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_sequencer
//  Purpose  : Directed bench for pc_fetch_sequencer. Each cycle the stimulus
//             process drives inputs and queues the hand-computed output
//             vector; a monitor pops and compares on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_sequencer;

  localparam int PCW = 18;

  logic           clk = 1'b0;
  logic           rst;
  logic [PCW-1:0] pc_cur;
  logic           pc_write;
  logic [PCW-1:0] pc_next;
  logic           imem_req;
  logic           imem_ready;
  logic           stall;
  logic           br_taken;
  logic [PCW-1:0] br_target;
  logic           jump;
  logic [PCW-1:0] jump_target;
  logic           trap;
  logic           fetch_valid;
  logic           flush;
  logic           err;
  logic [1:0]     state_o;

  // Environment PC register, with an override to plant arbitrary PCs.
  logic [PCW-1:0] pc_reg = '0;
  logic           ovr    = 1'b0;
  logic [PCW-1:0] ovr_val = '0;
  assign pc_cur = ovr ? ovr_val : pc_reg;

  always @(posedge clk) if (pc_write) pc_reg <= pc_next;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .pc_cur      (pc_cur),
    .pc_write    (pc_write),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .trap        (trap),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .err         (err),
    .state_o     (state_o)
  );

  // Vector layout: {pc_write, pc_next, imem_req, fetch_valid, flush, err, state}
  typedef struct {
    string       nm;
    logic [24:0] v;
    logic [24:0] m;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin : mon
    exp_t        e;
    logic [24:0] act;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {pc_write, pc_next, imem_req, fetch_valid, flush, err, state_o};
      n_chk++;
      if ((act & e.m) !== (e.v & e.m)) begin
        n_err++;
        $display("FAIL %s: got pw=%b pn=%h req=%b fv=%b fl=%b err=%b st=%0d, want pw=%b pn=%h req=%b fv=%b fl=%b err=%b st=%0d",
                 e.nm, act[24], act[23:6], act[5], act[4], act[3], act[2], act[1:0],
                 e.v[24], e.v[23:6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pc_next is only checked when a write is expected, or during reset.
  task automatic expect_out(input string nm, input logic [1:0] st, input logic pw,
                            input logic [PCW-1:0] pn, input logic rq, input logic fv,
                            input logic fl, input logic er);
    exp_t e;
    e.nm = nm;
    e.v  = {pw, pn, rq, fv, fl, er, st};
    e.m  = (pw || !rst) ? '1 : {1'b1, {PCW{1'b0}}, 6'b111111};
    q.push_back(e);
  endtask

  task automatic redir(input logic t, input logic b, input logic [PCW-1:0] bt,
                       input logic j, input logic [PCW-1:0] jt);
    trap = t; br_taken = b; br_target = bt; jump = j; jump_target = jt;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    redir(0, 0, '0, 0, '0);

    tick(); expect_out("reset", 0, 0, 18'h0, 0, 0, 0, 0);
    tick(); rst = 1'b1; expect_out("init", 0, 1, 18'h0, 0, 0, 0, 0);

    // Sequential fetch from 0
    tick(); expect_out("seq0", 1, 1, 18'h4, 1, 1, 0, 0);
    tick(); expect_out("seq4", 1, 1, 18'h8, 1, 1, 0, 0);
    tick(); expect_out("seq8", 1, 1, 18'hC, 1, 1, 0, 0);
    tick(); expect_out("seq12", 1, 1, 18'h10, 1, 1, 0, 0);

    // Stall at 0x10 for three cycles, then refetch 0x10
    tick(); stall = 1; expect_out("stall_fetch", 1, 0, 18'h0, 1, 0, 0, 0);
    tick(); expect_out("hold1", 3, 0, 18'h0, 0, 0, 0, 0);
    tick(); expect_out("hold2", 3, 0, 18'h0, 0, 0, 0, 0);
    tick(); stall = 0; expect_out("hold_rel", 3, 0, 18'h0, 0, 0, 0, 0);
    tick(); expect_out("refetch10", 1, 1, 18'h14, 1, 1, 0, 0);

    // Wrap at 2^18
    tick(); ovr = 1; ovr_val = 18'h3FFFC; expect_out("wrap", 1, 1, 18'h0, 1, 1, 0, 0);

    // Redirect priority
    tick(); ovr = 0; redir(1, 1, 18'h40, 1, 18'h60);
    expect_out("prio_trap", 1, 1, 18'h100, 1, 0, 1, 0);
    tick(); redir(0, 1, 18'h40, 1, 18'h60);
    expect_out("prio_br", 1, 1, 18'h40, 1, 0, 1, 0);
    tick(); redir(0, 0, 18'h0, 1, 18'h60);
    expect_out("prio_jump", 1, 1, 18'h60, 1, 0, 1, 0);

    // Memory wait with branch arriving in wait cycle 2
    tick(); redir(0, 0, '0, 0, '0); imem_ready = 0;
    expect_out("w_fetch", 1, 0, 18'h0, 1, 0, 0, 0);
    tick(); expect_out("w_cyc1", 2, 0, 18'h0, 1, 0, 0, 0);
    tick(); redir(0, 1, 18'h80, 0, '0); expect_out("w_cyc2_br", 2, 0, 18'h0, 1, 0, 1, 0);
    tick(); redir(0, 0, '0, 0, '0); expect_out("w_cyc3", 2, 0, 18'h0, 1, 0, 0, 0);
    tick(); imem_ready = 1; expect_out("w_pend_done", 2, 1, 18'h80, 1, 0, 0, 0);
    tick(); expect_out("fetch80", 1, 1, 18'h84, 1, 1, 0, 0);

    // Redirect in FETCH while memory not ready
    tick(); imem_ready = 0; redir(0, 0, '0, 1, 18'h200);
    expect_out("f_redir_busy", 1, 1, 18'h200, 1, 0, 1, 0);
    tick(); imem_ready = 1; redir(0, 0, '0, 0, '0);
    expect_out("w_pend200", 2, 1, 18'h200, 1, 0, 0, 0);
    tick(); expect_out("fetch200", 1, 1, 18'h204, 1, 1, 0, 0);

    // Redirect while in HOLD
    tick(); stall = 1; expect_out("stall204", 1, 0, 18'h0, 1, 0, 0, 0);
    tick(); redir(0, 1, 18'h300, 0, '0); expect_out("hold_br", 3, 1, 18'h300, 0, 0, 1, 0);
    tick(); stall = 0; redir(0, 0, '0, 0, '0);
    expect_out("fetch300", 1, 1, 18'h304, 1, 1, 0, 0);

    // Timeout: err on the 15th wait cycle
    tick(); imem_ready = 0; expect_out("to_fetch", 1, 0, 18'h0, 1, 0, 0, 0);
    for (int i = 1; i < 15; i++) begin
      tick(); expect_out($sformatf("to_wait%0d", i), 2, 0, 18'h0, 1, 0, 0, 0);
    end
    tick(); expect_out("timeout", 2, 1, 18'h100, 1, 0, 1, 1);
    tick(); imem_ready = 1; expect_out("fetch100", 1, 1, 18'h104, 1, 1, 0, 0);

    // Reset asserted mid-WAIT
    tick(); imem_ready = 0; expect_out("r_fetch", 1, 0, 18'h0, 1, 0, 0, 0);
    tick(); expect_out("r_wait1", 2, 0, 18'h0, 1, 0, 0, 0);
    tick(); rst = 0; expect_out("r_assert", 0, 0, 18'h0, 0, 0, 0, 0);
    tick(); expect_out("r_held", 0, 0, 18'h0, 0, 0, 0, 0);
    tick(); rst = 1; imem_ready = 1; expect_out("r_init", 0, 1, 18'h0, 0, 0, 0, 0);
    tick(); expect_out("r_fetch0", 1, 1, 18'h4, 1, 1, 0, 0);

    // Drain, bounded
    for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
